uart_transmitter: RTL

UART transmit side that pairs with the team's receiver: it serializes one byte per frame onto TxD.
- Frame format: start bit (0), 8 data bits LSB first, even-parity bit, stop bit (1).
- Bit timing comes from an internal 16x oversampling tick generator driven by baud_select, using the same baud table the receiver uses.
- The system-side interface is a single-byte write handshake with busy and done status.

---
 rtl/uart_transmitter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, even parity, one stop bit.
// Bit timing is 16 ticks of a divider selected by baud_select.
module uart_transmitter #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  localparam int unsigned DIV_W = 14;

  // Rounded clocks per 16x tick for a given baud rate
  function automatic logic [DIV_W-1:0] div_of(input int unsigned baud);
    return DIV_W'((CLK_HZ + 8 * baud) / (16 * baud));
  endfunction

  localparam logic [DIV_W-1:0] DIV_300    = div_of(300);
  localparam logic [DIV_W-1:0] DIV_1200   = div_of(1200);
  localparam logic [DIV_W-1:0] DIV_4800   = div_of(4800);
  localparam logic [DIV_W-1:0] DIV_9600   = div_of(9600);
  localparam logic [DIV_W-1:0] DIV_19200  = div_of(19200);
  localparam logic [DIV_W-1:0] DIV_38400  = div_of(38400);
  localparam logic [DIV_W-1:0] DIV_57600  = div_of(57600);
  localparam logic [DIV_W-1:0] DIV_115200 = div_of(115200);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_W-1:0] div_lat, div_lat_nxt;
  logic [DIV_W-1:0] div_sel;
  logic [3:0]       sample_cnt, sample_cnt_nxt;
  logic [3:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             parity, parity_nxt;
  logic             txd_nxt, busy_nxt, done_nxt;
  logic             tick;

  always_comb begin
    case (baud_select)
      3'b000:  div_sel = DIV_300;
      3'b001:  div_sel = DIV_1200;
      3'b010:  div_sel = DIV_4800;
      3'b011:  div_sel = DIV_9600;
      3'b100:  div_sel = DIV_19200;
      3'b101:  div_sel = DIV_38400;
      3'b110:  div_sel = DIV_57600;
      default: div_sel = DIV_115200;
    endcase
  end

  // Next-state and next-output logic; divider is frozen at 0 while idle
  always_comb begin
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    div_lat_nxt    = div_lat;
    sample_cnt_nxt = sample_cnt;
    bit_idx_nxt    = bit_idx;
    shift_nxt      = shift;
    parity_nxt     = parity;
    txd_nxt        = TxD;
    busy_nxt       = Tx_BUSY;
    done_nxt       = 1'b0;
    tick           = (div_cnt == div_lat - DIV_W'(1));

    if (state == IDLE) begin
      div_cnt_nxt = '0;
      if (Tx_WR && Tx_EN) begin
        state_nxt      = START;
        shift_nxt      = Tx_DATA;
        parity_nxt     = ^Tx_DATA;
        div_lat_nxt    = div_sel;
        sample_cnt_nxt = '0;
        bit_idx_nxt    = '0;
        txd_nxt        = 1'b0;
        busy_nxt       = 1'b1;
      end
    end else begin
      div_cnt_nxt = tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        sample_cnt_nxt = sample_cnt + 4'd1;
        if (sample_cnt == 4'd15) begin
          case (state)
            START: begin
              state_nxt   = DATA;
              bit_idx_nxt = '0;
              txd_nxt     = shift[0];
              shift_nxt   = shift >> 1;
            end
            DATA: begin
              if (bit_idx == 4'd7) begin
                state_nxt = PARITY;
                txd_nxt   = parity;
              end else begin
                bit_idx_nxt = bit_idx + 4'd1;
                txd_nxt     = shift[0];
                shift_nxt   = shift >> 1;
              end
            end
            PARITY: begin
              state_nxt = STOP;
              txd_nxt   = 1'b1;
            end
            STOP: begin
              state_nxt = IDLE;
              txd_nxt   = 1'b1;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      div_lat    <= '0;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      TxD        <= 1'b1;
      Tx_BUSY    <= 1'b0;
      Tx_DONE    <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      div_lat    <= div_lat_nxt;
      sample_cnt <= sample_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      parity     <= parity_nxt;
      TxD        <= txd_nxt;
      Tx_BUSY    <= busy_nxt;
      Tx_DONE    <= done_nxt;
    end
  end

endmodule
